// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; builds final write-back value (load / mul-div / ALU). Optional MS_ALE_CHECK_EN adds misaligned-load flag at bus bit 70.
// Latency: one register stage from exe; load and mul data are sampled in the first MS cycle and held until the instruction leaves.
// Backpressure: ms_allowin drops while an instruction is held and ws_allowin=0; the result stays stable for any stall length.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [77:0] es_to_ms_bus,
  output logic        ms_to_ws_valid,
`ifdef MS_ALE_CHECK_EN
  output logic [70:0] ms_to_ws_bus,
`else
  output logic [69:0] ms_to_ws_bus,
`endif
  output logic [38:0] ms_to_ds_forward_bus,
  output logic        ms_to_ds_valid,
  input  logic [31:0] data_sram_rdata,
  input  logic [63:0] mul_result,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  typedef struct packed {
    logic        sign_ext;
    logic [1:0]  mem_size;
    logic [3:0]  mul_div_op;
    logic        load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  logic        ms_valid;
  logic        ms_first;
  logic        ms_ready_go;
  es_bus_t     bus_r;
  logic [31:0] rdata_buf;
  logic [63:0] mul_buf;

  logic [31:0] mem_word;
  logic [63:0] prod;
  logic [1:0]  off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        forward_enable;
  logic        ws_gr_we;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_to_ds_valid = ms_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      ms_first  <= 1'b0;
      bus_r     <= '0;
      rdata_buf <= '0;
      mul_buf   <= '0;
    end else begin
      // SRAM and multiplier outputs are only valid in the first MS cycle
      if (ms_valid && ms_first) begin
        rdata_buf <= data_sram_rdata;
        mul_buf   <= mul_result;
      end
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
        bus_r    <= es_to_ms_bus;
        ms_first <= es_to_ms_valid;
      end else begin
        ms_first <= 1'b0;
      end
    end
  end

  assign mem_word = ms_first ? data_sram_rdata : rdata_buf;
  assign prod     = ms_first ? mul_result : mul_buf;
  assign off      = bus_r.alu_result[1:0];

  always_comb begin
    byte_v = mem_word[7:0];
    case (off)
      2'd0: byte_v = mem_word[7:0];
      2'd1: byte_v = mem_word[15:8];
      2'd2: byte_v = mem_word[23:16];
      2'd3: byte_v = mem_word[31:24];
      default: byte_v = mem_word[7:0];
    endcase
  end

  assign half_v = off[1] ? mem_word[31:16] : mem_word[15:0];

  // mem_size==11 falls into the byte branch
  always_comb begin
    load_data = mem_word;
    if (bus_r.mem_size[0]) begin
      load_data = {{24{bus_r.sign_ext & byte_v[7]}}, byte_v};
    end else if (bus_r.mem_size[1]) begin
      load_data = {{16{bus_r.sign_ext & half_v[15]}}, half_v};
    end
  end

  always_comb begin
    final_result = bus_r.alu_result;
    if (bus_r.load_op) begin
      final_result = load_data;
    end else if (bus_r.mul_div_op[0]) begin
      final_result = prod[31:0];
    end else if (bus_r.mul_div_op[1]) begin
      final_result = prod[63:32];
    end else if (bus_r.mul_div_op[2]) begin
      final_result = div_quotient;
    end else if (bus_r.mul_div_op[3]) begin
      final_result = div_remainder;
    end
  end

`ifdef MS_ALE_CHECK_EN
  logic ale;
  assign ale = ms_valid && bus_r.load_op &&
               ((bus_r.mem_size[1] && off[0]) || (bus_r.mem_size == 2'b00 && off != 2'b00));
  assign ws_gr_we       = bus_r.gr_we && !ale;
  assign forward_enable = ms_valid && bus_r.gr_we && (bus_r.dest != 5'd0) && !ale;
  assign ms_to_ws_bus   = {ale, ws_gr_we, bus_r.dest, final_result, bus_r.pc};
`else
  assign ws_gr_we       = bus_r.gr_we;
  assign forward_enable = ms_valid && bus_r.gr_we && (bus_r.dest != 5'd0);
  assign ms_to_ws_bus   = {ws_gr_we, bus_r.dest, final_result, bus_r.pc};
`endif

  // result is always final here, so decode never needs to stall on MS
  assign ms_to_ds_forward_bus = {1'b0, forward_enable, bus_r.dest, final_result};

endmodule
